evo_parity_evaluator: RTL and testbench

EVO_PARITY_EVALUATOR -- requirements
Module: evo_parity_evaluator

---
 rtl/evo_test_pkg.sv | 16 +
 rtl/bit_sync2.sv | 25 ++
 rtl/evo_parity_evaluator.sv | 150 +++++++++++++++
 tb/tb_evo_parity_evaluator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/evo_test_pkg.sv
// Shared types for the parity evaluator: FSM states and the
// expected-function selector values.
package evo_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE_A,
        SAMPLE_B,
        DONE
    } state_e;

    localparam int MODE_XOR  = 0;
    localparam int MODE_XNOR = 1;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer that brings the asynchronous CUT response
// into the clk domain.
module bit_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/evo_parity_evaluator.sv
// Sweeps every stimulus vector through a CUT, samples its response twice
// and scores it against XOR/XNOR parity.
module evo_parity_evaluator
    import evo_test_pkg::*;
#(
    parameter int N_INPUTS      = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int REPEATS       = 2,
    parameter int MODE          = 0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic                                          abort,
    output logic [N_INPUTS-1:0]                           cut_in,
    input  logic                                          cut_out,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          pass,
    output logic [$clog2(REPEATS*(2**N_INPUTS)+1)-1:0]    mismatch_cnt,
    output logic [$clog2(REPEATS*(2**N_INPUTS)+1)-1:0]    unstable_cnt,
    output logic [$clog2(REPEATS*(2**N_INPUTS)+1)-1:0]    fitness
);

    localparam int   TOTAL    = REPEATS * (2**N_INPUTS);
    localparam int   CW       = $clog2(TOTAL + 1);
    localparam int   SW       = $clog2(SETTLE_CYCLES);
    localparam int   RW       = $clog2(REPEATS + 1);
    localparam logic XNOR_BIT = (MODE == MODE_XNOR);

    state_e              state_q, state_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [RW-1:0]       sweep_q, sweep_d;
    logic [N_INPUTS-1:0] cut_in_q, cut_in_d;
    logic                s_a_q, s_a_d;
    logic [CW-1:0]       mis_q, mis_d;
    logic [CW-1:0]       uns_q, uns_d;
    logic [CW-1:0]       fit_q, fit_d;
    logic                pass_q, pass_d;
    logic                sync_out;
    logic                exp_bit;
    logic                last_vec;

    bit_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cut_out),
        .q     (sync_out)
    );

    assign exp_bit  = (^cut_in_q) ^ XNOR_BIT;
    assign last_vec = (&cut_in_q) && (sweep_q == RW'(REPEATS - 1));

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        sweep_d  = sweep_q;
        cut_in_d = cut_in_q;
        s_a_d    = s_a_q;
        mis_d    = mis_q;
        uns_d    = uns_q;
        fit_d    = fit_q;
        pass_d   = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                    sweep_d  = '0;
                    cut_in_d = '0;
                    mis_d    = '0;
                    uns_d    = '0;
                    fit_d    = '0;
                    pass_d   = 1'b0;
                end
            end
            SETTLE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE_A;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SAMPLE_A: begin
                s_a_d   = sync_out;
                state_d = SAMPLE_B;
            end
            SAMPLE_B: begin
                if (s_a_q != exp_bit) mis_d = mis_q + 1'b1;
                if (s_a_q != sync_out) uns_d = uns_q + 1'b1;
                if (last_vec) begin
                    state_d = DONE;
                end else begin
                    state_d  = SETTLE;
                    settle_d = '0;
                    cut_in_d = cut_in_q + 1'b1;
                    if (&cut_in_q) sweep_d = sweep_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                pass_d  = (mis_q == '0) && (uns_q == '0);
                fit_d   = CW'(TOTAL) - mis_q;
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, leaving partial counts visible.
        if (abort && state_q != IDLE) begin
            state_d  = IDLE;
            cut_in_d = cut_in_q;
            mis_d    = mis_q;
            uns_d    = uns_q;
            fit_d    = fit_q;
            pass_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
            sweep_q  <= '0;
            cut_in_q <= '0;
            s_a_q    <= 1'b0;
            mis_q    <= '0;
            uns_q    <= '0;
            fit_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            sweep_q  <= sweep_d;
            cut_in_q <= cut_in_d;
            s_a_q    <= s_a_d;
            mis_q    <= mis_d;
            uns_q    <= uns_d;
            fit_q    <= fit_d;
            pass_q   <= pass_d;
        end
    end

    assign cut_in       = cut_in_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE) && !abort;
    assign pass         = pass_q;
    assign mismatch_cnt = mis_q;
    assign unstable_cnt = uns_q;
    assign fitness      = fit_q;

endmodule

// File: tb/tb_evo_parity_evaluator.sv
// Directed bench for the parity evaluator: CUT models, abort and
// asynchronous reset behaviour.
module tb_evo_parity_evaluator;

    localparam int N  = 3;
    localparam int CW = $clog2(2 * (2**N) + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [N-1:0]  cut_in, cut_in_xn;
    logic          cut_out, cut_out_xn;
    logic          busy, busy_xn;
    logic          done, done_xn;
    logic          pass, pass_xn;
    logic [CW-1:0] mis, mis_xn;
    logic [CW-1:0] uns, uns_xn;
    logic [CW-1:0] fit, fit_xn;

    int   model_sel = 0;
    logic tog = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   cyc;

    always #5 clk = ~clk;
    always @(negedge clk) tog <= ~tog;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    always_comb begin
        cut_out = 1'b0;
        case (model_sel)
            0: cut_out = ^cut_in;
            1: cut_out = 1'b0;
            2: cut_out = ~^cut_in;
            3: cut_out = tog;
            default: cut_out = 1'b0;
        endcase
    end
    assign cut_out_xn = ~^cut_in_xn;

    evo_parity_evaluator #(
        .N_INPUTS(N), .SETTLE_CYCLES(4), .REPEATS(2), .MODE(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cut_in(cut_in), .cut_out(cut_out), .busy(busy), .done(done),
        .pass(pass), .mismatch_cnt(mis), .unstable_cnt(uns),
        .fitness(fit)
    );

    evo_parity_evaluator #(
        .N_INPUTS(N), .SETTLE_CYCLES(4), .REPEATS(2), .MODE(1)
    ) u_dut_xn (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cut_in(cut_in_xn), .cut_out(cut_out_xn), .busy(busy_xn),
        .done(done_xn), .pass(pass_xn), .mismatch_cnt(mis_xn),
        .unstable_cnt(uns_xn), .fitness(fit_xn)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic run(input bit extra, output int n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            start = extra && (n % 20 == 7);
        end
        start = 1'b0;
        chk("run_done", 32'(done), 1);
        @(posedge clk); #1;
        chk("done_1cyc", 32'(done), 0);
        chk("busy_end", 32'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("rst_cut_in", 32'(cut_in), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_fit", 32'(fit), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle_busy", 32'(busy), 0);

        model_sel = 0;
        run(1'b1, cyc);
        chk("xor_cycles", 32'(cyc), 96);
        chk("xor_mis", 32'(mis), 0);
        chk("xor_uns", 32'(uns), 0);
        chk("xor_fit", 32'(fit), 16);
        chk("xor_pass", 32'(pass), 1);
        chk("xor_done_cnt", 32'(done_cnt), 1);
        chk("xn_mis", 32'(mis_xn), 0);
        chk("xn_fit", 32'(fit_xn), 16);
        chk("xn_pass", 32'(pass_xn), 1);
        repeat (5) @(posedge clk);
        #1 chk("hold_fit", 32'(fit), 16);

        model_sel = 1;
        run(1'b0, cyc);
        chk("zero_mis", 32'(mis), 8);
        chk("zero_uns", 32'(uns), 0);
        chk("zero_fit", 32'(fit), 8);
        chk("zero_pass", 32'(pass), 0);

        model_sel = 2;
        run(1'b0, cyc);
        chk("xnor_mis", 32'(mis), 16);
        chk("xnor_fit", 32'(fit), 0);
        chk("xnor_pass", 32'(pass), 0);

        model_sel = 3;
        run(1'b0, cyc);
        chk("tog_uns", 32'(uns), 16);
        chk("tog_pass", 32'(pass), 0);

        model_sel = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ab_busy_hi", 32'(busy), 1);
        repeat (39) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_mis", 32'(mis), 3);
        chk("ab_pass", 32'(pass), 0);
        repeat (10) @(posedge clk);
        #1 chk("ab_no_done", 32'(done_cnt), 4);
        chk("ab_hold_mis", 32'(mis), 3);

        model_sel = 0;
        run(1'b0, cyc);
        chk("re_cycles", 32'(cyc), 96);
        chk("re_fit", 32'(fit), 16);
        chk("re_pass", 32'(pass), 1);

        model_sel = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1 chk("pre_rst_mis", 32'(mis), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cut_in", 32'(cut_in), 0);
        chk("arst_mis", 32'(mis), 0);
        chk("arst_uns", 32'(uns), 0);
        chk("arst_fit", 32'(fit), 0);
        chk("arst_pass", 32'(pass), 0);
        chk("arst_done", 32'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("post_rst_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
